// File: rtl/dual_port_halfword_ram_pkg.sv
// Shared parameters for the core and its halfword-organised unified memory.
`timescale 1ns/1ps
package dual_port_halfword_ram_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned HW_BITS = 16;
  localparam int unsigned XLEN_HW = XLEN / HW_BITS;

  typedef logic [HW_BITS-1:0] halfword_t;

  // Bit position of lane k inside a WIDTH-bit access word.
  function automatic int unsigned lane_lsb(input int unsigned k);
    return k * HW_BITS;
  endfunction

endpackage

// File: rtl/dual_port_halfword_ram.sv
// Unified instruction/data RAM: two asynchronous halfword-addressed read ports
// returning BURST consecutive halfwords, one full-width synchronous write port.
`timescale 1ns/1ps
module dual_port_halfword_ram
  import dual_port_halfword_ram_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN,
  parameter int unsigned DEPTH = 1048576,
  parameter int unsigned BURST = WIDTH / HW_BITS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             write_en,
  input  logic [WIDTH-2:0] iaddr,
  input  logic [WIDTH-2:0] daddr,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] inst_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  halfword_t     words [0:DEPTH-1];
  logic [AW-1:0] iidx  [BURST];
  logic [AW-1:0] didx  [BURST];
  logic          wr_en_c;

  // Lane indices wrap silently at the top of the array (low AW bits only).
  always_comb begin
    for (int unsigned k = 0; k < BURST; k++) begin
      iidx[k] = AW'(iaddr) + AW'(k);
      didx[k] = AW'(daddr) + AW'(k);
    end
  end

  // Reset only suppresses stores; the array itself is never cleared.
  always_comb begin
    wr_en_c = write_en & ~reset;
  end

  for (genvar k = 0; k < int'(BURST); k++) begin : g_lane
    assign inst_o[lane_lsb(k) +: HW_BITS] = words[iidx[k]];
    assign data_o[lane_lsb(k) +: HW_BITS] = words[didx[k]];
  end

  always_ff @(posedge clock) begin
    if (wr_en_c) begin
      for (int unsigned k = 0; k < BURST; k++) begin
        words[didx[k]] <= data_i[lane_lsb(k) +: HW_BITS];
      end
    end
  end

endmodule

// File: tb/tb_dual_port_halfword_ram.sv
// Directed bench for dual_port_halfword_ram: 32-bit and 64-bit instances, 1024-deep.
`timescale 1ns/1ps
module tb_dual_port_halfword_ram;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        we32 = 1'b0;
  logic [30:0] ia32 = '0;
  logic [30:0] da32 = '0;
  logic [31:0] di32 = '0;
  logic [31:0] do32;
  logic [31:0] io32;

  logic        we64 = 1'b0;
  logic [62:0] ia64 = '0;
  logic [62:0] da64 = '0;
  logic [63:0] di64 = '0;
  logic [63:0] do64;
  logic [63:0] io64;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dual_port_halfword_ram #(.WIDTH(32), .DEPTH(1024), .BURST(2)) u32 (
    .clock(clock), .reset(reset), .write_en(we32),
    .iaddr(ia32), .daddr(da32), .data_i(di32),
    .data_o(do32), .inst_o(io32)
  );

  dual_port_halfword_ram #(.WIDTH(64), .DEPTH(1024), .BURST(4)) u64 (
    .clock(clock), .reset(reset), .write_en(we64),
    .iaddr(ia64), .daddr(da64), .data_i(di64),
    .data_o(do64), .inst_o(io64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr32(input logic [30:0] a, input logic [31:0] d);
    @(negedge clock);
    da32 = a; di32 = d; we32 = 1'b1;
    @(negedge clock);
    we32 = 1'b0;
  endtask

  initial begin
    // Reset with no writes, then release.
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Preload words[0..3] through the store port.
    wr32(31'h0, 32'h2222_1111);
    wr32(31'h2, 32'h4444_3333);
    ia32 = 31'h1; da32 = 31'h2;
    #1;
    check("preload_inst", 64'(io32), 64'h3333_2222);
    check("preload_data", 64'(do32), 64'h4444_3333);
    check("preload_w0", 64'(u32.words[0]), 64'h1111);
    check("preload_w3", 64'(u32.words[3]), 64'h4444);

    // Store at 0x10: old value before the edge, new value after, on both ports.
    wr32(31'h10, 32'h0BAD_0BAD);
    @(negedge clock);
    da32 = 31'h10; ia32 = 31'h10; di32 = 32'hDEAD_BEEF; we32 = 1'b1;
    #1;
    check("pre_edge_data", 64'(do32), 64'h0BAD_0BAD);
    check("pre_edge_inst", 64'(io32), 64'h0BAD_0BAD);
    @(posedge clock); #1;
    check("post_edge_data", 64'(do32), 64'hDEAD_BEEF);
    check("post_edge_inst", 64'(io32), 64'hDEAD_BEEF);
    check("w10", 64'(u32.words[16'h10]), 64'hBEEF);
    check("w11", 64'(u32.words[16'h11]), 64'hDEAD);
    @(negedge clock);
    we32 = 1'b0;

    // Misaligned store partially overlapping an aligned fetch window.
    wr32(31'h20, 32'h5A5A_A5A5);
    wr32(31'h22, 32'h3C3C_C3C3);
    @(negedge clock);
    ia32 = 31'h20; da32 = 31'h21; di32 = 32'hAABB_CCDD; we32 = 1'b1;
    #1;
    check("mis_pre_inst", 64'(io32), 64'h5A5A_A5A5);
    @(posedge clock); #1;
    check("mis_post_inst", 64'(io32), 64'hCCDD_A5A5);
    check("mis_w20", 64'(u32.words[16'h20]), 64'hA5A5);
    check("mis_w21", 64'(u32.words[16'h21]), 64'hCCDD);
    check("mis_w22", 64'(u32.words[16'h22]), 64'hAABB);
    check("mis_w23", 64'(u32.words[16'h23]), 64'h3C3C);
    @(negedge clock);
    we32 = 1'b0;

    // Wrap at the top of the array, plus truncation of high address bits.
    wr32(31'd1023, 32'h1234_5678);
    ia32 = 31'd1023;
    #1;
    check("wrap_w1023", 64'(u32.words[1023]), 64'h5678);
    check("wrap_w0", 64'(u32.words[0]), 64'h1234);
    check("wrap_inst", 64'(io32), 64'h1234_5678);
    ia32 = 31'd2047;
    #1;
    check("wrap_high_bits", 64'(io32), 64'h1234_5678);

    // Reset blocks stores; outputs and contents are unaffected.
    wr32(31'h5, 32'h6666_5555);
    @(negedge clock);
    reset = 1'b1; we32 = 1'b1; da32 = 31'h5; ia32 = 31'h5; di32 = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    check("rst_w5", 64'(u32.words[5]), 64'h5555);
    check("rst_w6", 64'(u32.words[6]), 64'h6666);
    check("rst_inst", 64'(io32), 64'h6666_5555);
    check("rst_data", 64'(do32), 64'h6666_5555);
    @(negedge clock);
    reset = 1'b0; we32 = 1'b0; da32 = 31'h2;
    #1;
    check("post_rst_data", 64'(do32), 64'h4444_3333);

    // 64-bit instance: four lanes per access.
    @(negedge clock);
    da64 = 63'h3; di64 = 64'h0123_4567_89AB_CDEF; we64 = 1'b1;
    @(negedge clock);
    we64 = 1'b0; ia64 = 63'h3;
    #1;
    check("w64_w3", 64'(u64.words[3]), 64'hCDEF);
    check("w64_w4", 64'(u64.words[4]), 64'h89AB);
    check("w64_w5", 64'(u64.words[5]), 64'h4567);
    check("w64_w6", 64'(u64.words[6]), 64'h0123);
    check("w64_data", do64, 64'h0123_4567_89AB_CDEF);
    check("w64_inst", io64, 64'h0123_4567_89AB_CDEF);

    // 64-bit store straddling the wrap point.
    @(negedge clock);
    da64 = 63'd1022; di64 = 64'h1111_2222_3333_4444; we64 = 1'b1;
    @(negedge clock);
    we64 = 1'b0; ia64 = 63'd1022;
    #1;
    check("w64_wrap_w1", 64'(u64.words[1]), 64'h1111);
    check("w64_wrap_w1023", 64'(u64.words[1023]), 64'h3333);
    check("w64_wrap_inst", io64, 64'h1111_2222_3333_4444);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
